// File: rtl/tcb_lib_register_request_pkg.sv
// Shared types and helpers for the TCB request-path register slice.
//
// Contents:
//   TCB_ABW/DBW/SLW/BEW  bus widths shared by both ports of the slice
//   tcb_req_t            request payload {wen, adr, ben, wdt}
//   tcb_rsp_t            response payload {rdt, err}
//   tcb_lane_en()        expands byte enables into per-byte load enables,
//                        where every byte of a GRN-byte lane loads together
package tcb_lib_register_request_pkg;

  localparam int TCB_ABW = 32;
  localparam int TCB_DBW = 32;
  localparam int TCB_SLW = 8;
  localparam int TCB_BEW = TCB_DBW / TCB_SLW;

  typedef struct packed {
    logic               wen;
    logic [TCB_ABW-1:0] adr;
    logic [TCB_BEW-1:0] ben;
    logic [TCB_DBW-1:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  // Byte b is enabled when any byte enable inside its lane (index / grn) is set.
  // Called with a constant grn, so the loops fold into plain OR trees.
  function automatic logic [TCB_BEW-1:0] tcb_lane_en(input logic [TCB_BEW-1:0] ben,
                                                     input int grn);
    logic [TCB_BEW-1:0] en;
    en = '0;
    for (int b = 0; b < TCB_BEW; b++) begin
      for (int i = 0; i < TCB_BEW; i++) begin
        if ((i / grn) == (b / grn)) begin
          en[b] = en[b] | ben[i];
        end
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/tcb_lib_register_request_delay_tracker.sv
// Outstanding-transfer tracker for fixed-latency TCB slices.
//
// A DLY-deep shift register records which cycles carried a handshake; a
// handshake bit reaching the last stage marks the end of its response slot.
// A saturating counter follows handshakes minus ended slots.
//
// Ports:
//   clk   input  1  clock, rising edge
//   rst   input  1  asynchronous reset, active low
//   hs    input  1  handshake on the upstream side this cycle
//   busy  output 1  at least one transfer outstanding
module tcb_lib_delay_tracker #(
  parameter int DLY = 2
)(
  input  logic clk,
  input  logic rst,
  input  logic hs,
  output logic busy
);

  localparam int             CW      = $clog2(DLY + 2);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DLY + 1);

  if (DLY < 1) begin : g_bad_dly
    $error("tcb_lib_delay_tracker: DLY must be at least 1");
  end

  logic [DLY-1:0] sr_q;
  logic [DLY-1:0] sr_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           slot_end;

  for (genvar gi = 0; gi < DLY; gi++) begin : g_sr
    if (gi == 0) begin : g_head
      assign sr_d[gi] = hs;
    end else begin : g_tail
      assign sr_d[gi] = sr_q[gi-1];
    end
  end

  assign slot_end = sr_q[DLY-1];

  // A new handshake and an ending slot in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (hs && !slot_end) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (!hs && slot_end) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/tcb_lib_register_request.sv
// TCB request-path register slice.
//
// Registers the request between an upstream manager and a fixed-latency,
// never-stalling subordinate, adding one cycle of request latency. The
// response path is wired straight through. Payload registers only load on a
// transfer so the downstream bus stays quiet while idle.
//
// Ports:
//   clk      input   1    clock, rising edge
//   rst      input   1    asynchronous reset, active low
//   sub_*    -       -    subordinate port (from upstream manager), latency DLY+1
//   man_*    -       -    manager port (to downstream subordinate), latency DLY
//   err_stl  output  1    sticky: downstream deasserted man_rdy under man_vld
//   busy     output  1    a request is registered or a response is pending
module tcb_lib_register_request
  import tcb_lib_register_request_pkg::*;
#(
  parameter int GRN          = 1,
  parameter int DLY          = 1,
  parameter bit STALL_ASSERT = 1'b1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               sub_vld,
  output logic               sub_rdy,
  input  logic               sub_wen,
  input  logic [TCB_ABW-1:0] sub_adr,
  input  logic [TCB_BEW-1:0] sub_ben,
  input  logic [TCB_DBW-1:0] sub_wdt,
  output logic [TCB_DBW-1:0] sub_rdt,
  output logic               sub_err,
  output logic               man_vld,
  input  logic               man_rdy,
  output logic               man_wen,
  output logic [TCB_ABW-1:0] man_adr,
  output logic [TCB_BEW-1:0] man_ben,
  output logic [TCB_DBW-1:0] man_wdt,
  input  logic [TCB_DBW-1:0] man_rdt,
  input  logic               man_err,
  output logic               err_stl,
  output logic               busy
);

  if (GRN < 1 || (TCB_BEW % GRN) != 0) begin : g_bad_grn
    $error("tcb_lib_register_request: byte lanes must be a multiple of GRN");
  end

  logic               sub_rdy_q;
  logic               sub_rdy_d;
  logic               man_vld_q;
  logic               man_vld_d;
  logic               err_stl_q;
  logic               err_stl_d;
  tcb_req_t           req_q;
  tcb_req_t           req_d;
  tcb_rsp_t           rsp;
  logic               xfer;
  logic [TCB_BEW-1:0] lane_en;
  logic [TCB_BEW-1:0] byte_ld;

  assign xfer    = sub_vld & sub_rdy_q;
  assign lane_en = tcb_lane_en(sub_ben, GRN);

  // Write data bytes load per lane, only on writes touching that lane.
  for (genvar gi = 0; gi < TCB_BEW; gi++) begin : g_byte_ld
    assign byte_ld[gi] = xfer & sub_wen & lane_en[gi];
  end

  always_comb begin
    sub_rdy_d = 1'b1;
    man_vld_d = xfer;
    // The slice has no skid buffer: a stalled request is simply lost.
    err_stl_d = err_stl_q | (man_vld_q & ~man_rdy);
    req_d     = req_q;
    if (xfer) begin
      req_d.wen = sub_wen;
      req_d.adr = sub_adr;
      req_d.ben = sub_ben;
    end
    for (int b = 0; b < TCB_BEW; b++) begin
      if (byte_ld[b]) begin
        req_d.wdt[b*TCB_SLW +: TCB_SLW] = sub_wdt[b*TCB_SLW +: TCB_SLW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_rdy_q <= 1'b0;
      man_vld_q <= 1'b0;
      err_stl_q <= 1'b0;
      req_q     <= '0;
    end else begin
      sub_rdy_q <= sub_rdy_d;
      man_vld_q <= man_vld_d;
      err_stl_q <= err_stl_d;
      req_q     <= req_d;
    end
  end

  tcb_lib_delay_tracker #(
    .DLY (DLY + 1)
  ) u_trk (
    .clk  (clk),
    .rst  (rst),
    .hs   (xfer),
    .busy (busy)
  );

  assign rsp.rdt = man_rdt;
  assign rsp.err = man_err;

  assign sub_rdy = sub_rdy_q;
  assign sub_rdt = rsp.rdt;
  assign sub_err = rsp.err;
  assign man_vld = man_vld_q;
  assign man_wen = req_q.wen;
  assign man_adr = req_q.adr;
  assign man_ben = req_q.ben;
  assign man_wdt = req_q.wdt;
  assign err_stl = err_stl_q;

  if (STALL_ASSERT) begin : g_stall_chk
    always_ff @(posedge clk) begin
      if (rst && man_vld_q) begin
        assert (man_rdy) else $error("tcb_lib_register_request: downstream stall, request dropped");
      end
    end
  end

endmodule

// File: tb/tb_tcb_lib_register_request.sv
module tb_tcb_lib_register_request;

  localparam int GRN = 1;

  logic        clk;
  logic        rst;
  logic        sub_vld;
  logic        sub_rdy;
  logic        sub_wen;
  logic [31:0] sub_adr;
  logic [3:0]  sub_ben;
  logic [31:0] sub_wdt;
  logic [31:0] sub_rdt;
  logic        sub_err;
  logic        man_vld;
  logic        man_rdy;
  logic        man_wen;
  logic [31:0] man_adr;
  logic [3:0]  man_ben;
  logic [31:0] man_wdt;
  logic [31:0] man_rdt;
  logic        man_err;
  logic        err_stl;
  logic        busy;

  int tests_run;
  int tests_failed;
  int cyc;

  tcb_lib_register_request #(
    .GRN          (GRN),
    .DLY          (1),
    .STALL_ASSERT (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sub_vld (sub_vld),
    .sub_rdy (sub_rdy),
    .sub_wen (sub_wen),
    .sub_adr (sub_adr),
    .sub_ben (sub_ben),
    .sub_wdt (sub_wdt),
    .sub_rdt (sub_rdt),
    .sub_err (sub_err),
    .man_vld (man_vld),
    .man_rdy (man_rdy),
    .man_wen (man_wen),
    .man_adr (man_adr),
    .man_ben (man_ben),
    .man_wdt (man_wdt),
    .man_rdt (man_rdt),
    .man_err (man_err),
    .err_stl (err_stl),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream subordinate stub: latency 1, never stalls, err on adr[31].
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (man_vld && man_rdy) begin
      if (man_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (man_ben[b]) mem[man_adr[9:2]][b*8 +: 8] <= man_wdt[b*8 +: 8];
        end
      end else begin
        man_rdt <= mem[man_adr[9:2]];
        man_err <= man_adr[31];
      end
    end
  end

  // Reference model: what the downstream bus and the response must look like.
  logic [31:0] ref_mem   [0:255];
  logic [31:0] ref_vmask [0:255];
  logic        exp_rdy;
  logic        exp_mv;
  logic        exp_wen;
  logic [31:0] exp_adr;
  logic [3:0]  exp_ben;
  logic [31:0] exp_wdt;
  logic        exp_err_stl;
  logic        hs_prev;
  int          exp_cnt;
  logic        rsp_pending;
  logic [31:0] rsp_data;
  logic [31:0] rsp_mask;
  logic        rsp_err;

  task automatic model_reset();
    exp_rdy     = 1'b0;
    exp_mv      = 1'b0;
    exp_wen     = 1'b0;
    exp_adr     = '0;
    exp_ben     = '0;
    exp_wdt     = '0;
    exp_err_stl = 1'b0;
    hs_prev     = 1'b0;
    exp_cnt     = 0;
    rsp_pending = 1'b0;
  endtask

  // Drives one cycle of stimulus, advances the model, returns #1 after the edge.
  task automatic drive_cycle(input logic vld, input logic wen, input logic [31:0] adr,
                             input logic [3:0] ben, input logic [31:0] wdt, input logic mrdy);
    logic hs;
    logic consume;
    logic any;
    int   idx;
    sub_vld = vld;
    sub_wen = wen;
    sub_adr = adr;
    sub_ben = ben;
    sub_wdt = wdt;
    man_rdy = mrdy;
    hs      = vld && exp_rdy && rst;
    consume = exp_mv && mrdy && rst;
    rsp_pending = 1'b0;
    if (consume) begin
      idx = int'(exp_adr[9:2]);
      if (exp_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (exp_ben[b]) begin
            ref_mem[idx][b*8 +: 8]   = exp_wdt[b*8 +: 8];
            ref_vmask[idx][b*8 +: 8] = 8'hFF;
          end
        end
      end else begin
        rsp_pending = 1'b1;
        rsp_data    = ref_mem[idx];
        rsp_mask    = ref_vmask[idx];
        rsp_err     = exp_adr[31];
      end
    end
    if (exp_mv && !mrdy && rst) exp_err_stl = 1'b1;
    exp_cnt = int'(hs) + int'(hs_prev);
    hs_prev = hs;
    exp_mv  = hs;
    if (hs) begin
      exp_wen = wen;
      exp_adr = adr;
      exp_ben = ben;
      if (wen) begin
        for (int b = 0; b < 4; b++) begin
          any = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if ((i / GRN) == (b / GRN) && ben[i]) any = 1'b1;
          end
          if (any) exp_wdt[b*8 +: 8] = wdt[b*8 +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) exp_rdy = 1'b1;
    if (hs) $display("[TB] cyc %0d %s adr=%h ben=%h wdt=%h", cyc, wen ? "WR" : "RD", adr, ben, wdt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      tests_run++;
      if (man_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_man_vld: got %b want 0", man_vld); end
      tests_run++;
      if (sub_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_sub_rdy: got %b want 0", sub_rdy); end
      tests_run++;
      if (busy !== 1'b0 || err_stl !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err_stl); end
      tests_run++;
      if (man_adr !== 32'h0 || man_wdt !== 32'h0 || man_ben !== 4'h0 || man_wen !== 1'b0) begin
        tests_failed++; $display("FAIL reset_payload: got adr=%h wdt=%h ben=%h wen=%b want zeros", man_adr, man_wdt, man_ben, man_wen);
      end
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (sub_rdy !== 1'b0) begin tests_failed++; $display("FAIL release_rdy_early: got %b want 0", sub_rdy); end
    idle(1);
    tests_run++;
    if (sub_rdy !== 1'b1) begin tests_failed++; $display("FAIL release_rdy: got %b want 1", sub_rdy); end
  endtask

  task automatic test_write_read();
    drive_cycle(1'b1, 1'b1, 32'h10, 4'hF, 32'h01234567, 1'b1);
    tests_run++;
    if (man_vld !== 1'b1 || man_wen !== 1'b1 || man_adr !== 32'h10 || man_ben !== 4'hF || man_wdt !== 32'h01234567) begin
      tests_failed++; $display("FAIL wr_request: got vld=%b wen=%b adr=%h ben=%h wdt=%h want 1 1 00000010 f 01234567", man_vld, man_wen, man_adr, man_ben, man_wdt);
    end
    idle(1);
    tests_run++;
    if (man_vld !== 1'b0) begin tests_failed++; $display("FAIL wr_vld_pulse: got %b want 0", man_vld); end
    drive_cycle(1'b1, 1'b0, 32'h10, 4'h0, 32'hDEADBEEF, 1'b1);
    tests_run++;
    if (man_vld !== 1'b1 || man_wen !== 1'b0 || man_adr !== 32'h10 || man_wdt !== 32'h01234567) begin
      tests_failed++; $display("FAIL rd_request: got vld=%b wen=%b adr=%h wdt=%h want 1 0 00000010 01234567", man_vld, man_wen, man_adr, man_wdt);
    end
    idle(1);
    tests_run++;
    if (sub_rdt !== 32'h01234567 || sub_err !== 1'b0) begin
      tests_failed++; $display("FAIL rd_response: got rdt=%h err=%b want 01234567 0", sub_rdt, sub_err);
    end
    tests_run++;
    if (man_vld !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL rd_slot: got vld=%b busy=%b want 0 1", man_vld, busy); end
    idle(1);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_partial_write();
    drive_cycle(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1);
    idle(1);
    drive_cycle(1'b1, 1'b1, 32'h20, 4'h3, 32'hAABBCCDD, 1'b1);
    tests_run++;
    if (man_wdt !== 32'h1122CCDD || man_ben !== 4'h3) begin
      tests_failed++; $display("FAIL partial_wdt: got wdt=%h ben=%h want 1122ccdd 3", man_wdt, man_ben);
    end
    idle(1);
    drive_cycle(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b1);
    idle(1);
    tests_run++;
    if (sub_rdt !== 32'h1122CCDD) begin tests_failed++; $display("FAIL partial_read: got %h want 1122ccdd", sub_rdt); end
    tests_run++;
    if (man_wdt !== 32'h1122CCDD) begin tests_failed++; $display("FAIL read_no_wdt_load: got %h want 1122ccdd", man_wdt); end
  endtask

  task automatic test_back_to_back();
    int exp_c [0:5];
    int peak;
    exp_c = '{1, 2, 2, 2, 1, 0};
    peak  = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive_cycle(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'hB0B00000 | 32'(i), 1'b1);
      else       idle(1);
      tests_run++;
      if (man_vld !== (i < 4)) begin tests_failed++; $display("FAIL b2b_vld[%0d]: got %b want %b", i, man_vld, (i < 4)); end
      tests_run++;
      if (dut.u_trk.cnt_q !== 2'(exp_c[i]) || busy !== (exp_c[i] != 0)) begin
        tests_failed++; $display("FAIL b2b_cnt[%0d]: got cnt=%0d busy=%b want %0d %b", i, dut.u_trk.cnt_q, busy, exp_c[i], exp_c[i] != 0);
      end
      if (i < 4) begin
        tests_run++;
        if (man_adr !== 32'(i * 4)) begin tests_failed++; $display("FAIL b2b_adr[%0d]: got %h want %h", i, man_adr, 32'(i * 4)); end
      end
      if (int'(dut.u_trk.cnt_q) > peak) peak = int'(dut.u_trk.cnt_q);
    end
    tests_run++;
    if (peak != 2) begin tests_failed++; $display("FAIL b2b_peak: got %0d want 2", peak); end
  endtask

  task automatic test_idle_hold();
    logic [31:0] hold_wdt;
    logic [3:0]  hold_ben;
    int          toggles;
    drive_cycle(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);
    hold_wdt = exp_wdt;
    hold_ben = 4'hF;
    toggles  = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom, 1'b1);
      if (man_adr !== 32'h40 || man_wdt !== hold_wdt || man_ben !== hold_ben || man_wen !== 1'b0) toggles++;
    end
    tests_run++;
    if (toggles != 0) begin
      tests_failed++; $display("FAIL idle_hold: got %0d changed cycles (adr=%h wdt=%h ben=%h) want 0", toggles, man_adr, man_wdt, man_ben);
    end
  endtask

  task automatic test_random();
    logic [31:0] adr;
    logic        vld;
    for (int i = 0; i < 250; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      adr = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) == 0) adr = adr | 32'h80000000;
      drive_cycle(vld, 1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom, 1'b1);
      tests_run++;
      if (man_vld !== exp_mv || sub_rdy !== exp_rdy) begin
        tests_failed++; $display("FAIL rnd_vld_rdy cyc %0d: got %b%b want %b%b", cyc, man_vld, sub_rdy, exp_mv, exp_rdy);
      end
      tests_run++;
      if (man_wen !== exp_wen || man_adr !== exp_adr || man_ben !== exp_ben || man_wdt !== exp_wdt) begin
        tests_failed++; $display("FAIL rnd_payload cyc %0d: got %b %h %h %h want %b %h %h %h", cyc, man_wen, man_adr, man_ben, man_wdt, exp_wen, exp_adr, exp_ben, exp_wdt);
      end
      tests_run++;
      if (dut.u_trk.cnt_q !== 2'(exp_cnt) || busy !== (exp_cnt != 0) || err_stl !== exp_err_stl) begin
        tests_failed++; $display("FAIL rnd_status cyc %0d: got cnt=%0d busy=%b err=%b want %0d %b %b", cyc, dut.u_trk.cnt_q, busy, err_stl, exp_cnt, exp_cnt != 0, exp_err_stl);
      end
      if (rsp_pending) begin
        tests_run++;
        if (((sub_rdt ^ rsp_data) & rsp_mask) !== 32'h0 || sub_err !== rsp_err) begin
          tests_failed++; $display("FAIL rnd_rsp cyc %0d: got rdt=%h err=%b want %h (mask %h) %b", cyc, sub_rdt, sub_err, rsp_data, rsp_mask, rsp_err);
        end
      end
    end
  endtask

  task automatic test_stall();
    drive_cycle(1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 1'b1);
    tests_run++;
    if (man_vld !== 1'b1 || err_stl !== 1'b0) begin tests_failed++; $display("FAIL stall_pre: got vld=%b err=%b want 1 0", man_vld, err_stl); end
    drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    tests_run++;
    if (err_stl !== 1'b1) begin tests_failed++; $display("FAIL stall_set: got %b want 1", err_stl); end
    tests_run++;
    if (man_vld !== 1'b0) begin tests_failed++; $display("FAIL stall_no_retry: got %b want 0", man_vld); end
    idle(4);
    tests_run++;
    if (err_stl !== 1'b1) begin tests_failed++; $display("FAIL stall_sticky: got %b want 1", err_stl); end
    rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (err_stl !== 1'b0) begin tests_failed++; $display("FAIL stall_clear: got %b want 0", err_stl); end
    idle(1);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
    tests_run++;
    if (man_vld !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got vld=%b busy=%b want 1 1", man_vld, busy); end
    sub_vld = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (man_vld !== 1'b0 || busy !== 1'b0 || sub_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset: got vld=%b busy=%b rdy=%b want 0 0 0", man_vld, busy, sub_rdy);
    end
    tests_run++;
    if (dut.u_trk.cnt_q !== 2'd0) begin tests_failed++; $display("FAIL mid_cnt: got %0d want 0", dut.u_trk.cnt_q); end
    idle(2);
    rst = 1'b1;
    idle(1);
    tests_run++;
    if (sub_rdy !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_recover: got rdy=%b busy=%b want 1 0", sub_rdy, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst          = 1'b0;
    sub_vld      = 1'b0;
    sub_wen      = 1'b0;
    sub_adr      = '0;
    sub_ben      = '0;
    sub_wdt      = '0;
    man_rdy      = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = '0;
      ref_vmask[i] = '0;
    end
    model_reset();
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_idle_hold();
    test_random();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
